uart_rx_ctrl: RTL and testbench
===============================

Name: uart_rx_ctrl

Overview:
Control and buffering block that sits between the host-side logic and the UART receiver.
- Owns the receiver's runtime configuration (prescale, PAR_EN, PAR_TYP) and applies host change requests only when the serial line has been quiet for two bit-times, so a frame is never corrupted mid-reception.
- Captures each received byte on the rising edge of the receiver's stretched valid pulse into a small show-ahead FIFO, with overrun reporting.

Parameters:
DATA_WIDTH, 8, width of received data word
FIFO_DEPTH, 4, FIFO entries; must be a power of 2 and at least 2
DEF_PRESCALE, 8, prescale value loaded at reset
DEF_PAR_EN, 1, parity enable loaded at reset
DEF_PAR_TYP, 0, parity type loaded at reset (0 = even)

Ports:
clk  input  1  system clock
rst  input  1  asynchronous active-low reset
SRL_data  input  1  serial RX line; sampled for idle detection only
rx_data  input  DATA_WIDTH  receiver parallel output (P_DATA)
rx_valid  input  1  receiver Data_Valid_reg; multi-cycle high per byte
prescale  output  5  prescale value driven to the receiver
PAR_EN  output  1  parity enable driven to the receiver
PAR_TYP  output  1  parity type driven to the receiver
cfg_req  input  1  level request to change configuration; held until cfg_ack
cfg_prescale  input  5  requested prescale
cfg_par_en  input  1  requested parity enable
cfg_par_typ  input  1  requested parity type
cfg_ack  output  1  one-cycle pulse: request processed
cfg_err  output  1  one-cycle pulse coincident with cfg_ack: request rejected
rd_en  input  1  pop FIFO head
rd_data  output  DATA_WIDTH  FIFO head (show-ahead; valid when empty=0)
empty  output  1  FIFO empty
full  output  1  FIFO full
count  output  clog2(FIFO_DEPTH)+1  FIFO occupancy
overrun  output  1  sticky: a byte was dropped because the FIFO was full
ovr_clr  input  1  clears overrun

Behaviour:
- Reset (rst=0, asynchronous):
  - Outputs: prescale=DEF_PRESCALE, PAR_EN=DEF_PAR_EN, PAR_TYP=DEF_PAR_TYP, cfg_ack=0, cfg_err=0, overrun=0.
  - FIFO emptied: empty=1, full=0, count=0, rd_data=0.
  - FSM returns to RUN and idle_cnt=0.
  - A reset mid-request or mid-frame discards all pending state.
- Idle detector:
  - 7-bit idle_cnt increments (saturating at 127) each clock while SRL_data=1 and clears when SRL_data=0.
  - line_idle = (idle_cnt >= 2*prescale), evaluated against the currently applied prescale.
- Config FSM states: RUN, WAIT_IDLE, APPLY, DONE.
  - RUN: cfg_req=1 -> WAIT_IDLE.
  - WAIT_IDLE: line_idle=1 -> APPLY. A frame arriving while waiting holds the FSM in WAIT_IDLE; its byte is still captured normally.
  - APPLY (exactly one cycle):
    - If cfg_prescale is 8 or 16, register all three cfg_* values onto the outputs at the end of the cycle.
    - Otherwise leave the configuration unchanged and reject the request.
  - APPLY -> DONE.
  - DONE: registered cfg_ack=1 for this single cycle; cfg_err=1 in the same cycle if the request was rejected. If cfg_req=0 -> RUN, else remain in DONE (no further ack) until cfg_req falls.
  - cfg_* inputs are sampled only in APPLY.
- Push path:
  - rx_valid is registered to rx_valid_q; push = rx_valid & ~rx_valid_q (one push per byte regardless of pulse length).
  - rx_data is written into the FIFO at the same edge; empty falls and count increments after that edge.
- FIFO (circular; pointers wrap modulo FIFO_DEPTH):
  - rd_data = mem[rd_ptr], combinational from registered storage.
  - Pop on rd_en & ~empty; rd_en while empty is ignored, with no state change.
  - Push while full and no pop: byte dropped, overrun set, count unchanged.
  - Push and pop in the same cycle while full: both occur, count stays FIFO_DEPTH, no overrun.
  - Push and pop in the same cycle while empty: push only.
  - ovr_clr clears overrun; if ovr_clr and a dropping push occur in the same cycle, overrun ends at 1 (set wins).
  - full = (count==FIFO_DEPTH), empty = (count==0).

Test Plan:
- Reset -> prescale=8, PAR_EN=1, PAR_TYP=0, empty=1, count=0, overrun=0, cfg_ack=0.
- SRL_data held 1 for 20 clocks, cfg_req=1 with prescale 16 / par_en 0 / par_typ 1 -> cfg_ack pulses within 4 clocks; outputs become 16/0/1 with cfg_err=0; FSM stays in DONE until cfg_req drops.
- cfg_req raised 3 clocks after SRL_data falls (start bit) -> no ack until the line has been high for 16 consecutive clocks (prescale 8); prescale stays unchanged through the frame.
- cfg_prescale=12 on an idle line -> cfg_ack and cfg_err pulse together in the same cycle; prescale stays 8.
- rx_valid high for 8 cycles with rx_data=0xA5 -> exactly one push; rd_data=0xA5, count=1; rd_en for one cycle -> empty=1.
- Five bytes 0x01..0x05 pushed with no reads (FIFO_DEPTH=4) -> full=1, fifth byte dropped, overrun=1, rd_data=0x01. Then a push coincident with rd_en while full -> count stays 4, no new overrun. Then ovr_clr -> overrun=0.

Source files
------------

// File: rtl/uart_rx_ctrl_if.sv
// Host/receiver-facing signal bundle for uart_rx_ctrl.
// The slave modport is the controller's view; master is the host and receiver side.
interface uart_rx_ctrl_if #(
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 4
);
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  logic                  SRL_data;
  logic [DATA_WIDTH-1:0] rx_data;
  logic                  rx_valid;
  logic [4:0]            prescale;
  logic                  PAR_EN;
  logic                  PAR_TYP;
  logic                  cfg_req;
  logic [4:0]            cfg_prescale;
  logic                  cfg_par_en;
  logic                  cfg_par_typ;
  logic                  cfg_ack;
  logic                  cfg_err;
  logic                  rd_en;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  empty;
  logic                  full;
  logic [CNT_W-1:0]      count;
  logic                  overrun;
  logic                  ovr_clr;

  modport slave (
    input  SRL_data, rx_data, rx_valid, cfg_req, cfg_prescale, cfg_par_en,
           cfg_par_typ, rd_en, ovr_clr,
    output prescale, PAR_EN, PAR_TYP, cfg_ack, cfg_err, rd_data, empty, full,
           count, overrun
  );

  modport master (
    output SRL_data, rx_data, rx_valid, cfg_req, cfg_prescale, cfg_par_en,
           cfg_par_typ, rd_en, ovr_clr,
    input  prescale, PAR_EN, PAR_TYP, cfg_ack, cfg_err, rd_data, empty, full,
           count, overrun
  );
endinterface

// File: rtl/uart_rx_ctrl.sv
// UART receiver control: idle-gated configuration updates and a show-ahead
// byte FIFO fed by the rising edge of the receiver's stretched valid pulse.
module uart_rx_ctrl #(
  parameter int DATA_WIDTH   = 8,
  parameter int FIFO_DEPTH   = 4,
  parameter int DEF_PRESCALE = 8,
  parameter int DEF_PAR_EN   = 1,
  parameter int DEF_PAR_TYP  = 0
) (
  input logic            clk,
  input logic            rst,
  uart_rx_ctrl_if.slave  bus
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {RUN, WAIT_IDLE, APPLY, DONE} state_e;

  state_e     state_q;
  logic [6:0] idle_cnt_q;
  logic [4:0] prescale_q;
  logic       par_en_q;
  logic       par_typ_q;
  logic       cfg_ack_q;
  logic       cfg_err_q;
  logic       line_idle;
  logic       cfg_ok;

  // Two bit-times of quiet line, measured with the prescale currently in use.
  assign line_idle = idle_cnt_q >= {1'b0, prescale_q, 1'b0};
  assign cfg_ok    = (bus.cfg_prescale == 5'd8) || (bus.cfg_prescale == 5'd16);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      idle_cnt_q <= '0;
    end else if (!bus.SRL_data) begin
      idle_cnt_q <= '0;
    end else if (idle_cnt_q != 7'd127) begin
      idle_cnt_q <= idle_cnt_q + 7'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= RUN;
      prescale_q <= 5'(DEF_PRESCALE);
      par_en_q   <= 1'(DEF_PAR_EN);
      par_typ_q  <= 1'(DEF_PAR_TYP);
      cfg_ack_q  <= 1'b0;
      cfg_err_q  <= 1'b0;
    end else begin
      // NOTE: non-blocking defaults followed by overrides; the last scheduled
      // update wins, so ack/err are single-cycle pulses without extra logic.
      cfg_ack_q <= 1'b0;
      cfg_err_q <= 1'b0;
      case (state_q)
        RUN:       if (bus.cfg_req) state_q <= WAIT_IDLE;
        WAIT_IDLE: if (line_idle)   state_q <= APPLY;
        APPLY: begin
          if (cfg_ok) begin
            prescale_q <= bus.cfg_prescale;
            par_en_q   <= bus.cfg_par_en;
            par_typ_q  <= bus.cfg_par_typ;
          end
          cfg_ack_q <= 1'b1;
          cfg_err_q <= !cfg_ok;
          state_q   <= DONE;
        end
        DONE:      if (!bus.cfg_req) state_q <= RUN;
        default:   state_q <= RUN;
      endcase
    end
  end

  assign bus.prescale = prescale_q;
  assign bus.PAR_EN   = par_en_q;
  assign bus.PAR_TYP  = par_typ_q;
  assign bus.cfg_ack  = cfg_ack_q;
  assign bus.cfg_err  = cfg_err_q;

  logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]      count_q, count_d;
  logic                  overrun_q, overrun_d;
  logic                  rx_valid_q;
  logic                  push, pop, do_wr, drop, empty, full;

  assign empty = (count_q == '0);
  assign full  = (count_q == CNT_W'(FIFO_DEPTH));
  assign push  = bus.rx_valid & ~rx_valid_q;
  assign pop   = bus.rd_en & ~empty;
  // A pop frees the slot the same cycle, so a full FIFO can still accept.
  assign do_wr = push & (~full | pop);
  assign drop  = push & full & ~pop;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    count_d   = count_q;
    overrun_d = overrun_q;
    if (do_wr && !pop)      count_d = count_q + CNT_W'(1);
    else if (pop && !do_wr) count_d = count_q - CNT_W'(1);
    if (bus.ovr_clr) overrun_d = 1'b0;
    if (drop)        overrun_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_valid_q <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overrun_q  <= 1'b0;
      // NOTE: storage is reset because rd_data must read 0 straight out of reset;
      // at this depth the extra reset fan-out is negligible.
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
    end else begin
      rx_valid_q <= bus.rx_valid;
      count_q    <= count_d;
      overrun_q  <= overrun_d;
      if (do_wr) begin
        mem_q[wr_ptr_q] <= bus.rx_data;
        wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
      end
      if (pop) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
    end
  end

  assign bus.rd_data = mem_q[rd_ptr_q];
  assign bus.empty   = empty;
  assign bus.full    = full;
  assign bus.count   = count_q;
  assign bus.overrun = overrun_q;
endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Directed bench for uart_rx_ctrl: config handshake sequences plus a
// table of FIFO push/pop/overrun vectors with hand-computed expectations.
module tb_uart_rx_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  uart_rx_ctrl_if #(.DATA_WIDTH(8), .FIFO_DEPTH(4)) bus ();

  uart_rx_ctrl #(
    .DATA_WIDTH(8), .FIFO_DEPTH(4), .DEF_PRESCALE(8), .DEF_PAR_EN(1), .DEF_PAR_TYP(0)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  typedef struct {
    logic       vld;
    logic [7:0] data;
    logic       rd;
    logic       clr;
    int         cnt;
    logic       ovr;
    logic       chk_rd;
    logic [7:0] rdd;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic v, logic [7:0] d, logic r, logic c,
                              int cnt, logic ovr, logic chk, logic [7:0] rdd);
    vec_t t;
    t.vld = v; t.data = d; t.rd = r; t.clr = c;
    t.cnt = cnt; t.ovr = ovr; t.chk_rd = chk; t.rdd = rdd;
    return t;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic wait_ack(input int limit, output int lat, output logic err);
    lat = 0;
    err = 1'b0;
    for (int i = 1; i <= limit; i++) begin
      tick();
      if (bus.cfg_ack) begin
        lat = i;
        err = bus.cfg_err;
        break;
      end
    end
  endtask

  task automatic set_req(input logic req, input logic [4:0] p, input logic en, input logic typ);
    bus.cfg_req      = req;
    bus.cfg_prescale = p;
    bus.cfg_par_en   = en;
    bus.cfg_par_typ  = typ;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int   lat;
    logic err;
    logic ack_seen;
    logic cfg_moved;

    bus.SRL_data = 1'b1;
    bus.rx_data  = '0;
    bus.rx_valid = 1'b0;
    bus.rd_en    = 1'b0;
    bus.ovr_clr  = 1'b0;
    set_req(1'b0, 5'd0, 1'b0, 1'b0);

    // Reset state
    #12;
    check("rst prescale", bus.prescale, 8);
    check("rst par_en",   bus.PAR_EN, 1);
    check("rst par_typ",  bus.PAR_TYP, 0);
    check("rst empty",    bus.empty, 1);
    check("rst full",     bus.full, 0);
    check("rst count",    bus.count, 0);
    check("rst overrun",  bus.overrun, 0);
    check("rst cfg_ack",  bus.cfg_ack, 0);
    check("rst cfg_err",  bus.cfg_err, 0);
    check("rst rd_data",  bus.rd_data, 0);
    @(negedge clk);
    rst = 1'b1;
    tick();

    // Rejected request (prescale 12) on an idle line
    ticks(20);
    set_req(1'b1, 5'd12, 1'b0, 1'b1);
    wait_ack(10, lat, err);
    check("rej ack latency", lat, 3);
    check("rej cfg_err",     err, 1);
    check("rej prescale",    bus.prescale, 8);
    check("rej par_en",      bus.PAR_EN, 1);
    check("rej par_typ",     bus.PAR_TYP, 0);
    set_req(1'b0, 5'd0, 1'b0, 1'b0);
    tick();

    // Request raised mid-frame: must wait for 16 high clocks after the frame
    ack_seen  = 1'b0;
    cfg_moved = 1'b0;
    bus.SRL_data = 1'b0;
    for (int i = 0; i < 25; i++) begin
      if (i == 3) set_req(1'b1, 5'd8, 1'b1, 1'b1);
      if (i == 10) bus.SRL_data = 1'b1;
      if (i == 15) bus.SRL_data = 1'b0;
      tick();
      ack_seen  |= bus.cfg_ack;
      cfg_moved |= (bus.PAR_TYP != 1'b0) || (bus.prescale != 5'd8);
    end
    check("frame no early ack", ack_seen, 0);
    check("frame cfg held",     cfg_moved, 0);
    bus.SRL_data = 1'b1;
    wait_ack(40, lat, err);
    check("frame ack latency", lat, 18);
    check("frame cfg_err",     err, 0);
    check("frame par_typ",     bus.PAR_TYP, 1);
    check("frame prescale",    bus.prescale, 8);
    set_req(1'b0, 5'd0, 1'b0, 1'b0);
    tick();

    // Accepted request on an idle line, held in DONE while cfg_req stays high
    ticks(20);
    set_req(1'b1, 5'd16, 1'b0, 1'b1);
    wait_ack(4, lat, err);
    check("acc ack latency", lat, 3);
    check("acc cfg_err",     err, 0);
    check("acc prescale",    bus.prescale, 16);
    check("acc par_en",      bus.PAR_EN, 0);
    check("acc par_typ",     bus.PAR_TYP, 1);
    ack_seen = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      ack_seen |= bus.cfg_ack;
    end
    check("acc no re-ack", ack_seen, 0);
    set_req(1'b0, 5'd0, 1'b0, 1'b0);
    tick();

    // FIFO vectors: {vld, data, rd, clr, count, overrun, chk_rd, rd_data}
    for (int i = 0; i < 8; i++) vecs.push_back(mk(1, 8'hA5, 0, 0, 1, 0, 1, 8'hA5));
    vecs.push_back(mk(0, 8'h00, 1, 0, 0, 0, 0, 8'h00));
    vecs.push_back(mk(1, 8'h01, 0, 0, 1, 0, 1, 8'h01));
    vecs.push_back(mk(0, 8'h00, 0, 0, 1, 0, 1, 8'h01));
    vecs.push_back(mk(1, 8'h02, 0, 0, 2, 0, 1, 8'h01));
    vecs.push_back(mk(0, 8'h00, 0, 0, 2, 0, 1, 8'h01));
    vecs.push_back(mk(1, 8'h03, 0, 0, 3, 0, 1, 8'h01));
    vecs.push_back(mk(0, 8'h00, 0, 0, 3, 0, 1, 8'h01));
    vecs.push_back(mk(1, 8'h04, 0, 0, 4, 0, 1, 8'h01));
    vecs.push_back(mk(0, 8'h00, 0, 0, 4, 0, 1, 8'h01));
    vecs.push_back(mk(1, 8'h05, 0, 0, 4, 1, 1, 8'h01));
    vecs.push_back(mk(0, 8'h00, 0, 0, 4, 1, 1, 8'h01));
    vecs.push_back(mk(0, 8'h00, 0, 1, 4, 0, 1, 8'h01));
    vecs.push_back(mk(1, 8'h06, 1, 0, 4, 0, 1, 8'h02));
    vecs.push_back(mk(0, 8'h00, 0, 0, 4, 0, 1, 8'h02));
    vecs.push_back(mk(1, 8'h07, 0, 1, 4, 1, 1, 8'h02));
    vecs.push_back(mk(0, 8'h00, 0, 1, 4, 0, 1, 8'h02));
    vecs.push_back(mk(0, 8'h00, 1, 0, 3, 0, 1, 8'h03));
    vecs.push_back(mk(0, 8'h00, 1, 0, 2, 0, 1, 8'h04));
    vecs.push_back(mk(0, 8'h00, 1, 0, 1, 0, 1, 8'h06));
    vecs.push_back(mk(0, 8'h00, 1, 0, 0, 0, 0, 8'h00));
    vecs.push_back(mk(0, 8'h00, 1, 0, 0, 0, 0, 8'h00));
    vecs.push_back(mk(1, 8'h08, 1, 0, 1, 0, 1, 8'h08));
    vecs.push_back(mk(0, 8'h00, 1, 0, 0, 0, 0, 8'h00));

    foreach (vecs[i]) begin
      bus.rx_valid = vecs[i].vld;
      bus.rx_data  = vecs[i].data;
      bus.rd_en    = vecs[i].rd;
      bus.ovr_clr  = vecs[i].clr;
      tick();
      check($sformatf("vec%0d count", i),   bus.count, vecs[i].cnt);
      check($sformatf("vec%0d empty", i),   bus.empty, (vecs[i].cnt == 0));
      check($sformatf("vec%0d full", i),    bus.full, (vecs[i].cnt == 4));
      check($sformatf("vec%0d overrun", i), bus.overrun, vecs[i].ovr);
      if (vecs[i].chk_rd) check($sformatf("vec%0d rd_data", i), bus.rd_data, vecs[i].rdd);
    end
    bus.rx_valid = 1'b0;
    bus.rd_en    = 1'b0;
    bus.ovr_clr  = 1'b0;
    tick();

    // Reset while a byte is buffered and a request is waiting mid-frame
    bus.rx_valid = 1'b1;
    bus.rx_data  = 8'h5A;
    tick();
    bus.rx_valid = 1'b0;
    bus.SRL_data = 1'b0;
    set_req(1'b1, 5'd8, 1'b1, 1'b0);
    ticks(3);
    check("mid count before rst", bus.count, 1);
    rst = 1'b0;
    #1;
    check("mid rst count",    bus.count, 0);
    check("mid rst empty",    bus.empty, 1);
    check("mid rst rd_data",  bus.rd_data, 0);
    check("mid rst prescale", bus.prescale, 8);
    check("mid rst par_en",   bus.PAR_EN, 1);
    set_req(1'b0, 5'd0, 1'b0, 1'b0);
    bus.SRL_data = 1'b1;
    @(negedge clk);
    rst = 1'b1;
    tick();
    check("post rst cfg_ack", bus.cfg_ack, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
